// File: rtl/bullet_pool.sv
// bullet_pool: per-tank projectile manager with a parametrised N-slot pool.
// Each slot holds a bullet in sub-pixel fixed point that moves once per
// frame tick, bounces off walls through sticky hit flags, and retires on
// lifetime expiry, screen exit or an external kill. Shots are rate-limited
// by a cooldown counter that only arms when a bullet actually spawns.
module bullet_pool #(
    parameter int N_SLOTS  = 3,
    parameter int SPEED    = 2,
    parameter int LIFETIME = 300,
    parameter int COOLDOWN = 35,
    parameter int FRAC     = 7,
    parameter int SCR_W    = 640,
    parameter int SCR_H    = 480
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic                           frame_tick,
    input  logic                           fire,
    input  logic [9:0]                     tank_x,
    input  logic [9:0]                     tank_y,
    input  logic [7:0]                     dir_cos,
    input  logic [7:0]                     dir_sin,
    input  logic [N_SLOTS-1:0]             wall_left,
    input  logic [N_SLOTS-1:0]             wall_right,
    input  logic [N_SLOTS-1:0]             wall_top,
    input  logic [N_SLOTS-1:0]             wall_bottom,
    input  logic [N_SLOTS-1:0]             kill,
    output logic [10*N_SLOTS-1:0]          bullet_x,
    output logic [10*N_SLOTS-1:0]          bullet_y,
    output logic [N_SLOTS-1:0]             bullet_active,
    output logic [$clog2(N_SLOTS+1)-1:0]   active_count,
    output logic                           cooldown_busy
);

    // Position width, and an extended width so that a move can expose both
    // a negative result (top bit) and an overflow past 1023 px.
    localparam int PW = 10 + FRAC;
    localparam int EW = PW + 2;
    localparam int IW = EW - 1 - FRAC;
    localparam int CW = $clog2(N_SLOTS + 1);
    localparam int AW = ($clog2(LIFETIME + 1) > 9) ? $clog2(LIFETIME + 1) : 9;
    localparam int DW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    localparam logic [AW-1:0]        LIFE_MAX  = AW'(LIFETIME);
    localparam logic [DW-1:0]        COOL_LOAD = DW'(COOLDOWN);
    localparam logic [IW-1:0]        X_LIMIT   = IW'(SCR_W);
    localparam logic [IW-1:0]        Y_LIMIT   = IW'(SCR_H);
    localparam logic signed [11:0]   SPEED_S   = 12'(SPEED);

    // Per-slot state
    logic [PW-1:0]          px [N_SLOTS];
    logic [PW-1:0]          py [N_SLOTS];
    logic signed [11:0]     vx [N_SLOTS];
    logic signed [11:0]     vy [N_SLOTS];
    logic [AW-1:0]          age [N_SLOTS];
    logic [N_SLOTS-1:0]     lr;
    logic [N_SLOTS-1:0]     tb;
    logic [DW-1:0]          cooldown;

    // Next-state helpers
    logic signed [11:0]     eff_vx [N_SLOTS];
    logic signed [11:0]     eff_vy [N_SLOTS];
    logic [EW-1:0]          nx [N_SLOTS];
    logic [EW-1:0]          ny [N_SLOTS];
    logic [AW-1:0]          nage [N_SLOTS];
    logic [N_SLOTS-1:0]     free_slot;
    logic [N_SLOTS-1:0]     spawn_sel;
    logic [N_SLOTS-1:0]     move;
    logic [N_SLOTS-1:0]     retire;
    logic [N_SLOTS-1:0]     next_active;
    logic [CW-1:0]          next_count;
    logic                   spawn_ok;
    logic                   found;

    logic signed [11:0]     cos_ext;
    logic signed [11:0]     sin_ext;
    logic signed [11:0]     spawn_vx;
    logic signed [11:0]     spawn_vy;

    assign cos_ext  = {{4{dir_cos[7]}}, dir_cos};
    assign sin_ext  = {{4{dir_sin[7]}}, dir_sin};
    assign spawn_vx = cos_ext * SPEED_S;
    assign spawn_vy = sin_ext * SPEED_S;

    assign cooldown_busy = (cooldown != '0);

    // Work out this tick's moves, retirements and the spawn target slot.
    always_comb begin
        free_slot   = ~bullet_active & ~kill;
        spawn_ok    = frame_tick && fire && (cooldown == '0) && (|free_slot);
        spawn_sel   = '0;
        found       = 1'b0;
        move        = '0;
        retire      = '0;
        next_active = bullet_active;
        next_count  = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            eff_vx[i] = (lr[i] | wall_left[i] | wall_right[i]) ? -vx[i] : vx[i];
            eff_vy[i] = (tb[i] | wall_top[i] | wall_bottom[i]) ? -vy[i] : vy[i];
            nx[i]     = {2'b00, px[i]} + {{(EW-12){eff_vx[i][11]}}, eff_vx[i]};
            ny[i]     = {2'b00, py[i]} + {{(EW-12){eff_vy[i][11]}}, eff_vy[i]};
            nage[i]   = age[i] + AW'(1);
            move[i]   = frame_tick && bullet_active[i] && !kill[i];
            retire[i] = (nage[i] == LIFE_MAX)
                     || nx[i][EW-1] || (nx[i][EW-2:FRAC] >= X_LIMIT)
                     || ny[i][EW-1] || (ny[i][EW-2:FRAC] >= Y_LIMIT);
            if (!found && free_slot[i]) begin
                spawn_sel[i] = spawn_ok;
                found        = 1'b1;
            end
            if (kill[i]) begin
                next_active[i] = 1'b0;
            end else if (move[i] && retire[i]) begin
                next_active[i] = 1'b0;
            end else if (spawn_sel[i]) begin
                next_active[i] = 1'b1;
            end
            next_count = next_count + CW'(next_active[i]);
        end
    end

    // Slot registers: spawn loads, tick moves, walls latch sticky flags.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                px[i]  <= '0;
                py[i]  <= '0;
                vx[i]  <= '0;
                vy[i]  <= '0;
                age[i] <= '0;
            end
            lr            <= '0;
            tb            <= '0;
            bullet_active <= '0;
            active_count  <= '0;
        end else begin
            for (int i = 0; i < N_SLOTS; i++) begin
                if (spawn_sel[i]) begin
                    px[i]  <= {tank_x, {FRAC{1'b0}}};
                    py[i]  <= {tank_y, {FRAC{1'b0}}};
                    vx[i]  <= spawn_vx;
                    vy[i]  <= spawn_vy;
                    age[i] <= '0;
                end else if (move[i]) begin
                    px[i]  <= nx[i][PW-1:0];
                    py[i]  <= ny[i][PW-1:0];
                    vx[i]  <= eff_vx[i];
                    vy[i]  <= eff_vy[i];
                    age[i] <= nage[i];
                end
                if (spawn_sel[i] || frame_tick) begin
                    lr[i] <= 1'b0;
                    tb[i] <= 1'b0;
                end else if (bullet_active[i]) begin
                    lr[i] <= lr[i] | wall_left[i] | wall_right[i];
                    tb[i] <= tb[i] | wall_top[i] | wall_bottom[i];
                end
            end
            bullet_active <= next_active;
            active_count  <= next_count;
        end
    end

    // Cooldown arms on a real spawn and runs down one step per frame tick.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cooldown <= '0;
        end else if (|spawn_sel) begin
            cooldown <= COOL_LOAD;
        end else if (frame_tick && (cooldown != '0)) begin
            cooldown <= cooldown - DW'(1);
        end
    end

    // Integer pixel view of each slot's fixed-point position.
    always_comb begin
        bullet_x = '0;
        bullet_y = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            bullet_x[10*i +: 10] = px[i][PW-1:FRAC];
            bullet_y[10*i +: 10] = py[i][PW-1:FRAC];
        end
    end

endmodule
